// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode front end: PC, req/ack imem fetch, IR and valid/ready issue.
// Optional IFD_INSTR_CNT_EN adds a wrapping 32-bit accepted-instruction counter (instr_cnt).
module instr_fetch_decode #(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter int unsigned          OP_CODE_SIZE = 6,
  parameter int unsigned          FUNC_SIZE    = 11,
  parameter logic [PC_WIDTH-1:0]  PC_RESET     = '0,
  parameter logic [PC_WIDTH-1:0]  PC_INC       = PC_WIDTH'(4)
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req,
  output logic [PC_WIDTH-1:0]     imem_addr,
  input  logic                    imem_ack,
  input  logic [31:0]             imem_rdata,
  output logic                    instr_valid,
  input  logic                    cu_ready,
  output logic [OP_CODE_SIZE-1:0] opcode,
  output logic [FUNC_SIZE-1:0]    func,
  output logic [4:0]              rs1,
  output logic [4:0]              rs2,
  output logic [4:0]              rd,
  output logic [15:0]             imm,
  input  logic                    redirect_valid,
  input  logic [PC_WIDTH-1:0]     redirect_pc,
  input  logic                    halt,
`ifdef IFD_INSTR_CNT_EN
  output logic [31:0]             instr_cnt,
`endif
  output logic [PC_WIDTH-1:0]     pc_out
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StIssue = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [31:0]         ir_q, ir_d;
  logic                accept;

  assign accept = (state_q == StIssue) && cu_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    ir_d     = ir_q;
    unique case (state_q)
      StIdle: begin
        if (!halt) state_d = StFetch;
      end
      StFetch: begin
        if (imem_ack) begin
          ir_d     = imem_rdata;
          pc_out_d = pc_q;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (accept) begin
          // Redirect is only honoured in the accept cycle; the sum wraps naturally.
          pc_d    = redirect_valid ? redirect_pc : pc_q + PC_INC;
          state_d = halt ? StIdle : StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= PC_RESET;
      pc_out_q <= PC_RESET;
      ir_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      ir_q     <= ir_d;
    end
  end

`ifdef IFD_INSTR_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  assign cnt_d = accept ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_cnt = cnt_q;
`endif

  assign imem_req    = (state_q == StFetch);
  assign instr_valid = (state_q == StIssue);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_out_q;
  assign opcode      = ir_q[31 -: OP_CODE_SIZE];
  assign func        = ir_q[FUNC_SIZE-1:0];
  assign rs1         = ir_q[25:21];
  assign rs2         = ir_q[20:16];
  assign rd          = ir_q[15:11];
  assign imm         = ir_q[15:0];

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: per-cycle model comparison plus literal spot checks.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ack, instr_valid, cu_ready, redirect_valid, halt;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, pc_out;
  logic [5:0]  opcode;
  logic [10:0] func;
  logic [4:0]  rs1, rs2, rd;
  logic [15:0] imm;
`ifdef IFD_INSTR_CNT_EN
  logic [31:0] instr_cnt;
`endif

  int checks = 0;
  int errors = 0;

  instr_fetch_decode dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .cu_ready       (cu_ready),
    .opcode         (opcode),
    .func           (func),
    .rs1            (rs1),
    .rs2            (rs2),
    .rd             (rd),
    .imm            (imm),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
`ifdef IFD_INSTR_CNT_EN
    .instr_cnt      (instr_cnt),
`endif
    .pc_out         (pc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: "fetching" / "holding an instruction" flags plus the architectural values.
  logic        m_fetching, m_holding;
  logic [31:0] m_pc, m_ir, m_pc_out, m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fetching = 1'b0; m_holding = 1'b0;
      m_pc = 0; m_ir = 0; m_pc_out = 0; m_cnt = 0;
    end else if (m_holding) begin
      if (cu_ready) begin
        m_pc       = redirect_valid ? redirect_pc : m_pc + 32'd4;
        m_cnt      = m_cnt + 32'd1;
        m_holding  = 1'b0;
        m_fetching = !halt;
      end
    end else if (m_fetching) begin
      if (imem_ack) begin
        m_ir       = imem_rdata;
        m_pc_out   = m_pc;
        m_fetching = 1'b0;
        m_holding  = 1'b1;
      end
    end else if (!halt) begin
      m_fetching = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("req",    32'(imem_req),    32'(m_fetching));
    chk("valid",  32'(instr_valid), 32'(m_holding));
    chk("addr",   imem_addr,        m_pc);
    chk("pc_out", pc_out,           m_pc_out);
    chk("opcode", 32'(opcode),      m_ir >> 26);
    chk("func",   32'(func),        m_ir & 32'h7FF);
    chk("rs1",    32'(rs1),         (m_ir >> 21) & 32'h1F);
    chk("rs2",    32'(rs2),         (m_ir >> 16) & 32'h1F);
    chk("rd",     32'(rd),          (m_ir >> 11) & 32'h1F);
    chk("imm",    32'(imm),         m_ir & 32'hFFFF);
`ifdef IFD_INSTR_CNT_EN
    chk("cnt",    instr_cnt,        m_cnt);
`endif
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    cyc();
    while (!imem_req && n < budget) begin
      cyc();
      n++;
    end
    if (!imem_req) chk("req_timeout", 32'(imem_req), 32'd1);
  endtask

  task automatic pin_cnt(input logic [31:0] exp);
`ifdef IFD_INSTR_CNT_EN
    chk("lit_cnt", instr_cnt, exp);
`else
    if (exp == 32'hFFFF_FFFF) $display("unused %0d", exp);
`endif
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0022_1820; cu_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 0; halt = 1'b0;
    cyc(); cyc();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_func", 32'(func), 32'd0);
    pin_cnt(32'd0);

    // Zero-wait fetch of address 0.
    rst = 1'b0; imem_ack = 1'b1; cu_ready = 1'b1;
    wait_req(5);
    chk("lit_addr0", imem_addr, 32'h0);
    cyc();
    chk("lit_valid0", 32'(instr_valid), 32'd1);
    chk("lit_opcode", 32'(opcode), 32'h00);
    chk("lit_func", 32'(func), 32'h020);
    chk("lit_rs1", 32'(rs1), 32'd1);
    chk("lit_rs2", 32'(rs2), 32'd2);
    chk("lit_rd", 32'(rd), 32'd3);
    cyc();
    chk("lit_addr4", imem_addr, 32'h4);
    chk("lit_req4", 32'(imem_req), 32'd1);

    // Ack delayed 3 cycles at 0x4.
    imem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("lit_hold_req", 32'(imem_req), 32'd1);
      chk("lit_hold_addr", imem_addr, 32'h4);
      chk("lit_hold_valid", 32'(instr_valid), 32'd0);
    end
    imem_ack = 1'b1;
    cyc();
    chk("lit_valid4", 32'(instr_valid), 32'd1);
    chk("lit_pc_out4", pc_out, 32'h4);

    // Control unit stalls for 5 cycles; ack/rdata changes are ignored in issue.
    cu_ready = 1'b0; imem_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("lit_stall_valid", 32'(instr_valid), 32'd1);
      chk("lit_stall_req", 32'(imem_req), 32'd0);
      chk("lit_stall_func", 32'(func), 32'h020);
    end
    cu_ready = 1'b1; imem_ack = 1'b0;
    cyc();
    chk("lit_addr8", imem_addr, 32'h8);
    chk("lit_req8", 32'(imem_req), 32'd1);
    pin_cnt(32'd2);

    // Redirect pulse during fetch is ignored; redirect at accept is taken.
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    cyc();
    redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h8C43_0010;
    cyc();
    chk("lit_opcode23", 32'(opcode), 32'h23);
    chk("lit_imm", 32'(imm), 32'h0010);
    redirect_valid = 1'b1; redirect_pc = 32'h100; imem_ack = 1'b0;
    cyc();
    chk("lit_redirect", imem_addr, 32'h100);
    pin_cnt(32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    cyc();
    redirect_valid = 1'b0; imem_ack = 1'b1;
    cyc();
    chk("lit_pc_out100", pc_out, 32'h100);
    imem_ack = 1'b0;
    cyc();
    chk("lit_no_redirect", imem_addr, 32'h104);

    // Jump to the top of the address space, then wrap with halt at accept.
    imem_ack = 1'b1;
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ack = 1'b0;
    cyc();
    chk("lit_addr_top", imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0; imem_ack = 1'b1;
    cyc();
    halt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("lit_halt_req", 32'(imem_req), 32'd0);
      chk("lit_wrap_addr", imem_addr, 32'h0);
    end
    halt = 1'b0; imem_ack = 1'b0;
    cyc();
    chk("lit_resume_req", 32'(imem_req), 32'd1);
    imem_ack = 1'b1;
    cyc();
    imem_ack = 1'b0;
    cyc();
    chk("lit_addr4b", imem_addr, 32'h4);

    // Reset in the middle of a fetch; an ack arriving across reset is dropped.
    rst = 1'b1;
    #1;
    chk("lit_midrst_req", 32'(imem_req), 32'd0);
    chk("lit_midrst_addr", imem_addr, 32'h0);
    chk("lit_midrst_opcode", 32'(opcode), 32'h0);
    pin_cnt(32'd0);
    imem_ack = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("lit_late_ack_valid", 32'(instr_valid), 32'd0);
    chk("lit_refetch_addr", imem_addr, 32'h0);
    chk("lit_refetch_req", 32'(imem_req), 32'd1);
    cyc(); cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
